vga_pattern_gen: RTL
====================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical equivalents in lines.
REQ-006 SHALL have port clk  input  1  pixel clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port mode  input  2  pattern select: 0 solid, 1 ramp, 2 colour bars, 3 checker.
REQ-009 SHALL have port cfg_valid  input  1  write strobe for solid-colour staging register.
REQ-010 SHALL have port cfg_chan  input  2  target channel: 0 R, 1 G, 2 B, 3 ignored.
REQ-011 SHALL have port cfg_data  input  12  solid-colour segment code.
REQ-012 SHALL have ports hsync_n, vsync_n  output  1 each  active-low sync.
REQ-013 SHALL have port de  output  1  high during visible pixels.
REQ-014 SHALL have ports R, G, B  output  12 each  segment switch codes for the segmented DACs, bit 0 = sa1 ... bit 11 = sd3.

Function
REQ-015 SHALL keep hcount 0..H_total-1 (H_total = sum of H params), wrap to 0; vcount increments on hcount wrap, wraps 0 after V_total-1.
REQ-016 SHALL assert hsync_n low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync_n likewise on vcount.
REQ-017 SHALL assert de when hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-018 SHALL register all outputs; hsync_n, vsync_n, de, R, G, B correspond to the same counter state and appear 1 clock after it.
REQ-019 SHALL drive R=G=B=0 whenever de is low, regardless of mode.
REQ-020 SHALL, in mode 0, output active solid registers R_act/G_act/B_act.
REQ-021 SHALL, in mode 1, output R=G=B={hcount[9:0],hcount[9:8]} (plus offset per REQ-031).
REQ-022 SHALL, in mode 2, compute bar = hcount/80 (0..7); R=bar[2]?12'hFFF:0, G=bar[1]?12'hFFF:0, B=bar[0]?12'hFFF:0.
REQ-023 SHALL, in mode 3, output R=G=B = (hcount[5]^vcount[5]) ? 12'hFFF : 0.
REQ-024 SHALL write cfg_data to the staging register selected by cfg_chan on any clock with cfg_valid high; cfg_chan=3 writes nothing; no backpressure.
REQ-025 SHALL copy staging registers to active registers and sample mode into an active mode register only on the clock where counters wrap from (H_total-1,V_total-1) to (0,0); mid-frame changes have no visible effect.
REQ-026 SHALL, on cfg_valid coincident with frame wrap, write staging with the new value while active receives the prior staging value; new value appears next frame.
REQ-027 SHALL, on back-to-back cfg_valid to same channel, retain last write.

Reset
REQ-028 SHALL, while rst is high, clear hcount, vcount, staging, active and mode registers, and frame counter if present.
REQ-029 SHALL drive hsync_n=1, vsync_n=1, de=0, R=G=B=0 on the clock after rst asserts and while held.
REQ-030 SHALL, on rst released mid-frame, restart at (0,0) with active mode 0 and solid colour 0; first visible pixel outputs 1 clock after rst deasserts.

Configuration
REQ-031 SHALL, with PATTERN_ANIMATE_EN defined, keep an 8-bit frame counter incremented at each frame wrap (wraps 255->0) and add {frame,4'b0000} modulo 4096 to the mode 1 ramp code.
REQ-032 SHALL, without PATTERN_ANIMATE_EN, contain no frame counter; mode 1 ramp is static.

Verification
REQ-033 SHALL check timing: after rst, count 800 clocks per line, 525 lines per frame; hsync_n low exactly 96 clocks starting hcount 656; vsync_n low lines 490-491.
REQ-034 SHALL check solid colour: cfg writes R=12'h0F0, G=12'h00F, B=12'hF00 mid-frame, mode 0 -> current frame unchanged, next frame's first visible pixel R=0F0,G=00F,B=F00.
REQ-035 SHALL check colour bars: mode 2 -> pixel hcount 0 gives 000/000/000, hcount 80 gives B=FFF only, hcount 560 gives all FFF; hcount 640 gives all 0 with de low.
REQ-036 SHALL check wrap collision: cfg_valid R=12'hABC on the frame-wrap clock with staging R=12'h123 -> frame shows 123, following frame shows ABC.
REQ-037 SHALL check reset mid-frame: assert rst at hcount 300 line 200 for 3 clocks -> outputs idle values; after release counters restart at 0, mode 0, colour 0.
REQ-038 SHALL check ramp with PATTERN_ANIMATE_EN: mode 1, frame 2, hcount 1 -> R=G=B=12'h024; without macro -> 12'h004.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA raster timing with four selectable test patterns
// (solid, ramp, colour bars, checker). Solid colour and pattern mode are
// double-buffered and only take effect at the frame boundary.
// Optional feature: define PATTERN_ANIMATE_EN to add an 8-bit frame counter
// that scrolls the mode 1 ramp by {frame,4'b0000} each frame.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_chan,
  input  logic [11:0] cfg_data,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic [11:0] R,
  output logic [11:0] G,
  output logic [11:0] B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 11/6 bits so the ramp (hcount[9:0]) and
  // checker (bit 5) slices always exist.
  localparam int HW = ($clog2(H_TOTAL + 1) > 11) ? $clog2(H_TOTAL + 1) : 11;
  localparam int VW = ($clog2(V_TOTAL + 1) > 6) ? $clog2(V_TOTAL + 1) : 6;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_W  = HW'(80);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0]   FULL   = '1;

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          line_end, frame_end;

  logic [11:0]   r_stage_q, g_stage_q, b_stage_q;
  logic [11:0]   r_act_q, g_act_q, b_act_q;
  logic [1:0]    mode_q;

  logic [11:0]   ramp;
  logic [2:0]    bar;
  logic          chk;
  logic          hs_d, vs_d, de_d;
  logic [11:0]   r_d, g_d, b_d;

  // Next raster position and frame-boundary detection
  always_comb begin
    line_end  = (hcount_q == H_LAST);
    frame_end = line_end && (vcount_q == V_LAST);
    hcount_d  = hcount_q + 1'b1;
    vcount_d  = vcount_q;
    if (line_end) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
  end

  // Raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Staging registers: written any time, last write wins, channel 3 ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_q <= '0;
      g_stage_q <= '0;
      b_stage_q <= '0;
    end else if (cfg_valid) begin
      case (cfg_chan)
        2'd0:    r_stage_q <= cfg_data;
        2'd1:    g_stage_q <= cfg_data;
        2'd2:    b_stage_q <= cfg_data;
        default: ;
      endcase
    end
  end

  // Active colour and mode reload at the frame wrap; a coincident cfg write
  // only reaches staging, so active picks up the previous staging value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_q <= '0;
      g_act_q <= '0;
      b_act_q <= '0;
      mode_q  <= '0;
    end else if (frame_end) begin
      r_act_q <= r_stage_q;
      g_act_q <= g_stage_q;
      b_act_q <= b_stage_q;
      mode_q  <= mode;
    end
  end

`ifdef PATTERN_ANIMATE_EN
  logic [7:0] frame_q;

  // Frame counter advancing at each frame wrap, wrapping 255 -> 0
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else if (frame_end) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  assign ramp = {hcount_q[9:0], hcount_q[9:8]} + {frame_q, 4'b0000};
`else
  assign ramp = {hcount_q[9:0], hcount_q[9:8]};
`endif

  // Sync/blanking decode and pattern selection for the current position
  always_comb begin
    bar  = 3'(hcount_q / BAR_W);
    chk  = hcount_q[5] ^ vcount_q[5];
    de_d = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    hs_d = ~((hcount_q >= HS_BEG) && (hcount_q < HS_END));
    vs_d = ~((vcount_q >= VS_BEG) && (vcount_q < VS_END));
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    if (de_d) begin
      case (mode_q)
        2'd0: begin
          r_d = r_act_q;
          g_d = g_act_q;
          b_d = b_act_q;
        end
        2'd1: begin
          r_d = ramp;
          g_d = ramp;
          b_d = ramp;
        end
        2'd2: begin
          r_d = bar[2] ? FULL : '0;
          g_d = bar[1] ? FULL : '0;
          b_d = bar[0] ? FULL : '0;
        end
        default: begin
          r_d = chk ? FULL : '0;
          g_d = chk ? FULL : '0;
          b_d = chk ? FULL : '0;
        end
      endcase
    end
  end

  // Registered outputs, all aligned to the same counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      de      <= 1'b0;
      R       <= '0;
      G       <= '0;
      B       <= '0;
    end else begin
      hsync_n <= hs_d;
      vsync_n <= vs_d;
      de      <= de_d;
      R       <= r_d;
      G       <= g_d;
      B       <= b_d;
    end
  end

endmodule
